// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin front-end for two requesters onto one APB bus.
// This block runs the SETUP and ACCESS phases itself. It honours pready wait
// states and returns a one-cycle done pulse, read data and an error flag to
// the requester that won arbitration.
//
// Optional ACCESS-phase timeout: define APB_ARB_TIMEOUT_EN. When it is not
// defined the bus waits for pready indefinitely and reqN_err is tied low.
//
// state  | meaning
// IDLE   | bus parked (all APB outputs 0), arbitrating incoming requests
// SETUP  | psel=1, penable=0, winner's addr/dir/data latched on the bus
// ACCESS | psel=1, penable=1, waiting for pready (or the timeout limit)
module apb_rr_arbiter #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              presetn,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_wr,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_wr,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,

    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_psel;
    logic              w_psel_nxt;
    logic              r_penable;
    logic              w_penable_nxt;
    logic [ADDR_W-1:0] r_paddr;
    logic [ADDR_W-1:0] w_paddr_nxt;
    logic              r_pwrite;
    logic              w_pwrite_nxt;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] w_pwdata_nxt;

    // r_gnt: requester owning the current transfer; r_last_gnt: last winner
    logic              r_gnt;
    logic              w_gnt_nxt;
    logic              r_last_gnt;
    logic              w_last_gnt_nxt;

    logic [1:0]        r_done;
    logic [1:0]        w_done_nxt;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] w_rdata0_nxt;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] w_rdata1_nxt;

    logic              w_req_any;
    logic              w_win;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_win_wr;
    logic              w_finish;

`ifdef APB_ARB_TIMEOUT_EN
    // 8 bits covers the full legal TIMEOUT_CYC range of 2..255
    localparam int               TMO_W    = 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] w_tmo_cnt_nxt;
    logic [1:0]       r_err;
    logic [1:0]       w_err_nxt;
`endif

    assign w_req_any = req0_valid | req1_valid;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        w_win = 1'b0;
        if (req0_valid && req1_valid) begin
            w_win = ~r_last_gnt;
        end else if (req1_valid) begin
            w_win = 1'b1;
        end
    end

    assign w_win_addr  = w_win ? req1_addr  : req0_addr;
    assign w_win_wdata = w_win ? req1_wdata : req0_wdata;
    assign w_win_wr    = w_win ? req1_wr    : req0_wr;

    // State register
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        w_state_nxt    = r_state;
        w_psel_nxt     = r_psel;
        w_penable_nxt  = r_penable;
        w_paddr_nxt    = r_paddr;
        w_pwrite_nxt   = r_pwrite;
        w_pwdata_nxt   = r_pwdata;
        w_gnt_nxt      = r_gnt;
        w_last_gnt_nxt = r_last_gnt;
        w_done_nxt     = 2'b00;
        w_rdata0_nxt   = r_rdata0;
        w_rdata1_nxt   = r_rdata1;
        w_finish       = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_err_nxt      = 2'b00;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt    = S_SETUP;
                    w_psel_nxt     = 1'b1;
                    w_paddr_nxt    = w_win_addr;
                    w_pwrite_nxt   = w_win_wr;
                    w_pwdata_nxt   = w_win_wr ? w_win_wdata : '0;
                    w_gnt_nxt      = w_win;
                    w_last_gnt_nxt = w_win;
                end
            end

            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                w_tmo_cnt_nxt = '0;
`endif
            end

            S_ACCESS: begin
                if (pready) begin
                    w_finish = 1'b1;
                    // writes leave the requester's last read data untouched
                    if (!r_pwrite) begin
                        if (r_gnt) begin
                            w_rdata1_nxt = prdata;
                        end else begin
                            w_rdata0_nxt = prdata;
                        end
                    end
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    w_finish  = 1'b1;
                    w_err_nxt = r_gnt ? 2'b10 : 2'b01;
                    if (r_gnt) begin
                        w_rdata1_nxt = '0;
                    end else begin
                        w_rdata0_nxt = '0;
                    end
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
`endif
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Normal completion and timeout abort both park the bus and pulse done
        if (w_finish) begin
            w_state_nxt   = S_IDLE;
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
            w_paddr_nxt   = '0;
            w_pwrite_nxt  = 1'b0;
            w_pwdata_nxt  = '0;
            w_done_nxt    = r_gnt ? 2'b10 : 2'b01;
        end
    end

    // Output and bookkeeping registers; reset parks the bus and abandons any transfer
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_paddr    <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= '0;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_done     <= 2'b00;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_psel     <= w_psel_nxt;
            r_penable  <= w_penable_nxt;
            r_paddr    <= w_paddr_nxt;
            r_pwrite   <= w_pwrite_nxt;
            r_pwdata   <= w_pwdata_nxt;
            r_gnt      <= w_gnt_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_done     <= w_done_nxt;
            r_rdata0   <= w_rdata0_nxt;
            r_rdata1   <= w_rdata1_nxt;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    // ACCESS wait-state counter and error flags
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_tmo_cnt <= '0;
            r_err     <= 2'b00;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign req0_err = r_err[0];
    assign req1_err = r_err[1];
`else
    assign req0_err = 1'b0;
    assign req1_err = 1'b0;
`endif

    assign psel       = r_psel;
    assign penable    = r_penable;
    assign paddr      = r_paddr;
    assign pwrite     = r_pwrite;
    assign pwdata     = r_pwdata;
    assign req0_done  = r_done[0];
    assign req1_done  = r_done[1];
    assign req0_rdata = r_rdata0;
    assign req1_rdata = r_rdata1;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: scoreboard bench for apb_rr_arbiter.
// Stimulus issues requests and pushes the predicted APB transfer and done
// response. Two monitors pop and compare these when the DUT shows a SETUP
// phase or a done pulse.
module tb_apb_rr_arbiter;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;
`ifdef APB_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_wr = 1'b0, req1_wr = 1'b0;
    logic          req0_done, req1_done, req0_err, req1_err;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;

    apb_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_wr(req0_wr), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_wr(req1_wr), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          setup_cyc;
        logic [AW-1:0] addr;
        logic        wr;
        logic [DW-1:0] wdata;
        int          waits;
        logic [DW-1:0] prd;
    } bus_t;

    typedef struct {
        int          who;
        int          cyc;
        logic        err;
        logic [DW-1:0] rdata;
    } done_t;

    bus_t  bq[$];
    done_t dq[$];

    // reference model state
    int            m_last = 1;
    bit            m_pend [2];
    logic [DW-1:0] m_rdata [2];

    // APB slave + bus monitor
    bus_t cur;
    int   acc = 0;
    always @(negedge pclk) begin
        pready = 1'($urandom_range(0, 1));
        prdata = DW'($urandom);
        if (psel === 1'b1 && penable === 1'b0) begin
            if (bq.size() == 0) begin
                check("unexpected_setup", psel, 0);
            end else begin
                cur = bq.pop_front();
                acc = 0;
                check("setup_cycle", cyc, cur.setup_cyc);
                check("setup_paddr", paddr, cur.addr);
                check("setup_pwrite", pwrite, cur.wr);
                check("setup_pwdata", pwdata, cur.wdata);
            end
        end else if (psel === 1'b1 && penable === 1'b1) begin
            check("access_bus", {pwrite, paddr, pwdata}, {cur.wr, cur.addr, cur.wdata});
            if (acc == cur.waits) begin
                pready = 1'b1;
                prdata = cur.prd;
            end else begin
                pready = 1'b0;
            end
            acc++;
        end else begin
            check("idle_bus_zero", {psel, penable, pwrite, paddr, pwdata}, 0);
        end
    end

    // done monitor
    done_t de;
    always @(negedge pclk) begin
        if (req0_done === 1'b1 || req1_done === 1'b1) begin
            check("dual_done", req0_done & req1_done, 0);
            if (dq.size() == 0) begin
                check("unexpected_done", {req1_done, req0_done}, 0);
            end else begin
                de = dq.pop_front();
                check("done_who", req1_done ? 1 : 0, de.who);
                check("done_cycle", cyc, de.cyc);
                check("done_err", de.who ? req1_err : req0_err, de.err);
                check("done_rdata", de.who ? req1_rdata : req0_rdata, de.rdata);
            end
        end
    end

    // Called at a negedge where the DUT is idle (the done cycle of the previous
    // transfer, or later). A requester still pending from a lost tie keeps its valid.
    task automatic issue(input bit nv0, input bit nv1,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0, input bit w0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit w1,
                         input int gap, input int waits, input bit drop,
                         input logic [DW-1:0] prd);
        int    n, d, win;
        bit    v0, v1;
        bus_t  b;
        done_t e;
        if (!m_pend[0]) req0_valid = 1'b0;
        if (!m_pend[1]) req1_valid = 1'b0;
        if (!m_pend[0] && !m_pend[1]) repeat (gap) @(negedge pclk);
        if (!m_pend[0] && nv0) begin
            req0_valid = 1'b1; req0_addr = a0; req0_wdata = d0; req0_wr = w0;
        end
        if (!m_pend[1] && nv1) begin
            req1_valid = 1'b1; req1_addr = a1; req1_wdata = d1; req1_wr = w1;
        end
        v0 = req0_valid;
        v1 = req1_valid;
        if (!v0 && !v1) begin
            @(negedge pclk);
            return;
        end
        n = cyc;
        win = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
        m_last = win;
        m_pend[win] = 1'b0;
        if (v0 && v1) m_pend[1 - win] = 1'b1;
        b.setup_cyc = n + 1;
        b.addr  = win ? req1_addr : req0_addr;
        b.wr    = win ? req1_wr : req0_wr;
        b.wdata = b.wr ? (win ? req1_wdata : req0_wdata) : '0;
        b.waits = waits;
        b.prd   = prd;
        bq.push_back(b);
        e.who = win;
        if (TMO_EN && waits >= TMO) begin
            d = n + 2 + TMO;
            e.err = 1'b1;
            e.rdata = '0;
        end else begin
            d = n + 3 + waits;
            e.err = 1'b0;
            e.rdata = b.wr ? m_rdata[win] : prd;
        end
        m_rdata[win] = e.rdata;
        e.cyc = d;
        dq.push_back(e);
        @(negedge pclk);
        // granted requester's inputs now change; the DUT must ignore them
        if (win == 0) begin
            req0_addr = AW'($urandom); req0_wdata = DW'($urandom); req0_wr = 1'($urandom_range(0, 1));
            if (drop) req0_valid = 1'b0;
        end else begin
            req1_addr = AW'($urandom); req1_wdata = DW'($urandom); req1_wr = 1'($urandom_range(0, 1));
            if (drop) req1_valid = 1'b0;
        end
        while (cyc < d) @(negedge pclk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_apb"}, {psel, penable, pwrite, paddr, pwdata}, 0);
        check({tag, "_done"}, {req1_done, req0_done}, 0);
        check({tag, "_err"}, {req1_err, req0_err}, 0);
        check({tag, "_rdata"}, {req1_rdata, req0_rdata}, 0);
    endtask

    task automatic reset_mid_access();
        int   n;
        bus_t b;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'h6; req0_wdata = 8'h11; req0_wr = 1'b0;
        n = cyc;
        b.setup_cyc = n + 1; b.addr = 4'h6; b.wr = 1'b0; b.wdata = '0;
        b.waits = 1000; b.prd = 8'hEE;
        bq.push_back(b);
        @(negedge pclk);
        req0_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        check("pre_reset_access", {psel, penable}, 2'b11);
        presetn = 1'b0;
        @(negedge pclk);
        check_all_zero("midreset");
        presetn = 1'b1;
        m_last = 1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    endtask

    task automatic drain();
        while (m_pend[0] || m_pend[1])
            issue(0, 0, '0, '0, 0, '0, '0, 0, 0, 0, 1, DW'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int w;
        m_pend[0] = 1'b0; m_pend[1] = 1'b0;
        m_rdata[0] = '0; m_rdata[1] = '0;

        presetn = 1'b0;
        repeat (3) @(negedge pclk);
        check_all_zero("reset");
        presetn = 1'b1;

        // single write, zero wait
        issue(1, 0, 4'h3, 8'hA5, 1, '0, '0, 0, 0, 0, 0, 8'h00);
        // read with 3 wait states
        issue(0, 1, '0, '0, 0, 4'h9, 8'h77, 0, 0, 3, 1, 8'h5C);
        // contention: both continuously valid, grants alternate
        for (int i = 0; i < 4; i++)
            issue(1, 1, AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                  AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 0, 0, 0, DW'($urandom));
        drain();
        // requester drops valid during the transfer, then the bus must stay quiet
        issue(1, 0, 4'hC, 8'h3E, 0, '0, '0, 0, 1, 2, 1, 8'hB7);
        issue(0, 0, '0, '0, 0, '0, '0, 0, 0, 0, 1, 8'h00);
        repeat (4) @(negedge pclk);
        // reset during ACCESS, then a tie must go to requester 0
        reset_mid_access();
        issue(1, 1, 4'h1, 8'h21, 1, 4'h2, 8'h42, 1, 0, 1, 1, 8'h00);
        drain();
        // long waits around the timeout limit
        issue(1, 0, 4'h5, 8'h00, 0, '0, '0, 0, 1, TMO - 1, 1, 8'h9A);
        issue(0, 1, '0, '0, 0, 4'hA, 8'h00, 0, 1, TMO, 1, 8'h6B);
        issue(1, 0, 4'hF, 8'h00, 0, '0, '0, 0, 0, 120, 1, 8'hC3);
        drain();

        for (int r = 0; r < 60; r++) begin
            w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                  AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)), w, 1'($urandom_range(0, 1)), DW'($urandom));
        end
        drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (10) @(negedge pclk);
        check("bus_queue_left", bq.size(), 0);
        check("done_queue_left", dq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
